// File: rtl/axi_lite_regfile_slave_if.sv
// AXI4-Lite bus bundle between an interconnect master port and a register-file slave.
// Write address (aw_*), write data (w_*), write response (b_*), read address (ar_*)
// and read data (r_*) channels. Clock and reset stay outside the bundle.
interface axi_lite_regfile_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64
) ();
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] aw_addr;
  logic                  aw_valid;
  logic                  aw_ready;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  w_valid;
  logic                  w_ready;
  logic [1:0]            b_resp;
  logic                  b_valid;
  logic                  b_ready;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic                  ar_valid;
  logic                  ar_ready;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_valid;
  logic                  r_ready;

  modport master (
    output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );

  modport slave (
    input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );
endinterface

// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite slave exposing NUM_REGS word-wide memory-mapped registers to hardware.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus           : AXI4-Lite slave modport (AW/W/B write path, AR/R read path)
//   reg_q_o       : flat RW register values, slice i = reg i (RO slices read as 0)
//   reg_ro_i      : flat hardware values for read-only registers
//   reg_wr_o      : one-cycle pulse per register after a successful write
module axi_lite_regfile_slave #(
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter int unsigned          DATA_WIDTH = 64,
  parameter int unsigned          NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0]  RO_MASK    = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  axi_lite_regfile_slave_if.slave        bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_ro_i,
  output logic [NUM_REGS-1:0]            reg_wr_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned OFF_W      = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_W      = $clog2(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Word address beyond the register bank decodes to nothing.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >> OFF_W) < ADDR_WIDTH'(NUM_REGS);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] addr);
    return addr[OFF_W +: IDX_W];
  endfunction

  // State
  logic                  aw_held_q, aw_held_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
  logic                  aw_ready_q, aw_ready_d;
  logic                  w_ready_q, w_ready_d;
  logic                  b_valid_q, b_valid_d;
  logic [1:0]            b_resp_q, b_resp_d;
  logic                  ar_ready_q, ar_ready_d;
  logic                  r_valid_q, r_valid_d;
  logic [1:0]            r_resp_q, r_resp_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic [NUM_REGS-1:0]   reg_wr_q, reg_wr_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  // Combinational helpers
  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] ro_words [NUM_REGS];

  // Word views of the flat hardware-side buses.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_words
    assign ro_words[i] = reg_ro_i[i*DATA_WIDTH +: DATA_WIDTH];
    assign reg_q_o[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs_q[i];
  end

  // Next-state logic for both channels.
  always_comb begin
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    b_valid_d = b_valid_q;
    b_resp_d  = b_resp_q;
    r_valid_d = r_valid_q;
    r_resp_d  = r_resp_q;
    r_data_d  = r_data_q;
    reg_wr_d  = '0;
    regs_d    = regs_q;

    aw_hs = bus.aw_valid && aw_ready_q;
    w_hs  = bus.w_valid && w_ready_q;
    ar_hs = bus.ar_valid && ar_ready_q;

    // Address/data come from the holding buffer if one was captured earlier.
    wr_addr = aw_held_q ? aw_addr_q : bus.aw_addr;
    wr_data = w_held_q ? w_data_q : bus.w_data;
    wr_strb = w_held_q ? w_strb_q : bus.w_strb;
    wr_idx  = addr_idx(wr_addr);
    rd_idx  = addr_idx(bus.ar_addr);
    commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);

    if (b_valid_q && bus.b_ready) begin
      b_valid_d = 1'b0;
    end

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      b_valid_d = 1'b1;
      if (!addr_in_range(wr_addr)) begin
        b_resp_d = RESP_DECERR;
      end else if (RO_MASK[wr_idx]) begin
        b_resp_d = RESP_SLVERR;
      end else begin
        for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
          if (wr_strb[b]) begin
            regs_d[wr_idx][b*8 +: 8] = wr_data[b*8 +: 8];
          end
        end
        reg_wr_d[wr_idx] = 1'b1;
        b_resp_d         = RESP_OKAY;
      end
    end else begin
      if (aw_hs) begin
        aw_held_d = 1'b1;
        aw_addr_d = bus.aw_addr;
      end
      if (w_hs) begin
        w_held_d = 1'b1;
        w_data_d = bus.w_data;
        w_strb_d = bus.w_strb;
      end
    end

    if (r_valid_q && bus.r_ready) begin
      r_valid_d = 1'b0;
    end

    // Read samples pre-edge register state, so a same-cycle write is not visible.
    if (ar_hs) begin
      r_valid_d = 1'b1;
      if (!addr_in_range(bus.ar_addr)) begin
        r_data_d = '0;
        r_resp_d = RESP_DECERR;
      end else if (RO_MASK[rd_idx]) begin
        r_data_d = ro_words[rd_idx];
        r_resp_d = RESP_OKAY;
      end else begin
        r_data_d = regs_q[rd_idx];
        r_resp_d = RESP_OKAY;
      end
    end

    // Readies registered from the next state so they track buffer/response occupancy.
    aw_ready_d = !aw_held_d && !b_valid_d;
    w_ready_d  = !w_held_d && !b_valid_d;
    ar_ready_d = !r_valid_d;
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_held_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b1;
      b_valid_q  <= 1'b0;
      b_resp_q   <= 2'b00;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_resp_q   <= 2'b00;
      r_data_q   <= '0;
      reg_wr_q   <= '0;
      regs_q     <= '{default: '0};
    end else begin
      aw_held_q  <= aw_held_d;
      aw_addr_q  <= aw_addr_d;
      w_held_q   <= w_held_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      r_resp_q   <= r_resp_d;
      r_data_q   <= r_data_d;
      reg_wr_q   <= reg_wr_d;
      regs_q     <= regs_d;
    end
  end

  assign bus.aw_ready = aw_ready_q;
  assign bus.w_ready  = w_ready_q;
  assign bus.b_valid  = b_valid_q;
  assign bus.b_resp   = b_resp_q;
  assign bus.ar_ready = ar_ready_q;
  assign bus.r_valid  = r_valid_q;
  assign bus.r_resp   = r_resp_q;
  assign bus.r_data   = r_data_q;
  assign reg_wr_o     = reg_wr_q;

endmodule

// File: doc/axi_lite_regfile_slave.md
Name: axi_lite_regfile_slave

Overview:
- AXI4-Lite slave (responder) that terminates an AXI4-Lite master port and exposes a bank of memory-mapped, word-wide registers to hardware.
- Used for peripheral control/status blocks hung off the core's AXI4-Lite interconnect.
- Independent write path (AW/W/B) and read path (AR/R), each with a single outstanding transaction.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 64, AXI data width; 32 or 64 only. STRB_WIDTH = DATA_WIDTH/8.
- NUM_REGS, 8, number of registers; power of two, >= 2.
- RO_MASK, '0 (NUM_REGS bits), bit i set: register i is read-only and sourced from reg_ro_i.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- aw_addr_i  in  ADDR_WIDTH  write address
- aw_valid_i  in  1  AW valid
- aw_ready_o  out  1  AW ready
- w_data_i  in  DATA_WIDTH  write data
- w_strb_i  in  STRB_WIDTH  byte strobes
- w_valid_i  in  1  W valid
- w_ready_o  out  1  W ready
- b_resp_o  out  2  write response
- b_valid_o  out  1  B valid
- b_ready_i  in  1  B ready
- ar_addr_i  in  ADDR_WIDTH  read address
- ar_valid_i  in  1  AR valid
- ar_ready_o  out  1  AR ready
- r_data_o  out  DATA_WIDTH  read data
- r_resp_o  out  2  read response
- r_valid_o  out  1  R valid
- r_ready_i  in  1  R ready
- reg_q_o  out  NUM_REGS*DATA_WIDTH  current value of RW registers; slice i = reg i; RO slices drive 0
- reg_ro_i  in  NUM_REGS*DATA_WIDTH  hardware values for RO registers; slices of RW registers are ignored
- reg_wr_o  out  NUM_REGS  one-cycle pulse per register on a successful write

Behaviour:
- Reset (async on rst_ni low):
  - All RW registers become 0.
  - aw_ready_o = w_ready_o = ar_ready_o = 1.
  - b_valid_o = r_valid_o = 0; b_resp_o = r_resp_o = 0; r_data_o = 0; reg_wr_o = 0.
  - Holding buffers are cleared; an in-flight transaction is dropped with no response.
- Decode:
  - idx = addr[log2(STRB_WIDTH) +: log2(NUM_REGS)].
  - Address in range iff addr >> log2(STRB_WIDTH) < NUM_REGS.
  - Low offset bits are ignored (unaligned accesses are treated as aligned).
- Responses: OKAY 2'b00, SLVERR 2'b10, DECERR 2'b11.
- Write path:
  - AW and W are accepted independently in any order; each is held in a one-entry buffer.
  - aw_ready_o = !aw_held && !b_valid_o; w_ready_o = !w_held && !b_valid_o.
  - Commit cycle: first cycle in which both address and data are available, from a handshake in that cycle or from a buffer.
  - At the commit clock edge:
    - Out of range: no update, resp DECERR.
    - RO register: no update, resp SLVERR.
    - Otherwise: bytes with strobe set are written, others kept, resp OKAY, and reg_wr_o[idx] pulses in the following cycle.
    - A strobe of all zeros still returns OKAY and pulses reg_wr_o, with no change to the value.
  - Both buffers clear; b_valid_o rises in the cycle after commit.
  - AW and W handshaked in the same cycle T: register updated and b_valid_o high at T+1.
  - b_valid_o, b_resp_o hold stable until b_ready_i; B handshake clears b_valid_o.
  - New AW/W are accepted from the cycle after the B handshake (no overlap).
- Read path:
  - ar_ready_o = !r_valid_o.
  - On AR handshake at T: r_data_o/r_resp_o are captured from the pre-edge register state and r_valid_o = 1 at T+1.
  - Captured value: RW reg → stored value; RO reg → reg_ro_i slice sampled at T; out of range → data 0, DECERR.
  - R stays stable until r_ready_i; next AR is accepted the cycle after the R handshake.
- Simultaneous events:
  - Read handshake in the same cycle as a write commit to the same register returns the old value.
  - Read and write paths never stall each other.
- reg_q_o reflects register state combinationally from the flops (visible at T+1 after commit).

Test Plan:
- Reset then AW addr 0x08 + W data 0xDEADBEEF_CAFEF00D, strb 0xFF in the same cycle → next cycle b_valid=1 with resp 00, reg_wr_o=8'b0000_0010, reg_q_o slice1 = 0xDEADBEEFCAFEF00D.
- W presented 3 cycles before AW (addr 0x10, data 0x1122334455667788, strb 0x0F) with reg2 = 0 → w_ready low after acceptance, write commits on the AW handshake, slice2 = 0x0000000055667788, resp 00.
- RO_MASK=8'h01, reg_ro_i slice0 = 0xA5: write to 0x00 → SLVERR, reg_wr_o stays 0; read 0x00 → r_data=0xA5, r_resp 00.
- Read and write to 0x40 (idx out of range for NUM_REGS=8) → b_resp 11, r_resp 11, r_data 0, no register changes.
- b_ready_i held low 5 cycles → b_valid/b_resp stable and aw_ready/w_ready low throughout; after the B handshake aw_ready returns to 1 the next cycle. r_ready_i backpressure behaves the same for AR/R.
- Reg3 = 0x1; AR 0x18 and a write commit of 0x2 to 0x18 in the same cycle → r_data=0x1 and slice3 = 0x2 afterwards. rst_ni low mid-transaction → all outputs return to reset values immediately.
